ysyx_24090003_ifu_prefetch: RTL
===============================

# ysyx_24090003_ifu_prefetch

Parametrised instruction fetch unit with a prefetch queue. It issues in-order, pipelined fetch requests over a valid/ready request channel with an in-order response channel, and buffers up to `DEPTH` instructions with their PCs. It presents them to the IDU over a valid/ready handshake. Redirects flush the queue and discard in-flight responses. It sits between the PC/branch logic and instruction memory, replacing the single-outstanding two-phase fetcher.

## Interface
Parameters:
- `XLEN`, 32, PC and address width.
- `ILEN`, 32, instruction width.
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2. It also bounds outstanding requests.
- `RESET_PC`, 32'h8000_0000, first fetch address.

Ports:
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst`  in  1  reset; one clock, asynchronous assert, active-high.
- `i_redirect_valid`  in  1  redirect request; highest priority.
- `i_redirect_pc`  in  XLEN  redirect target; bits [1:0] must be 0.
- `o_req_valid`  out  1  fetch request valid.
- `i_req_ready`  in  1  memory accepts request.
- `o_req_addr`  out  XLEN  fetch address.
- `i_rsp_valid`  in  1  response valid; responses return in request order, never before the cycle after acceptance.
- `i_rsp_data`  in  ILEN  fetched instruction.
- `i_rsp_err`  in  1  bus error on this response.
- `o_inst_valid`  out  1  queue head valid.
- `i_inst_ready`  in  1  IDU accepts head.
- `o_inst`  out  ILEN  head instruction.
- `o_pc`  out  XLEN  head PC.
- `o_inst_err`  out  1  head carries a bus error.

## Operation
- FSM states:
  - IDLE: after reset; no request; next state is FETCH.
  - FETCH: issue requests.
  - ERR: no requests; left only by redirect, which goes to FETCH.
- Registers:
  - `fetch_pc`: next request address.
  - `rsp_pc`: PC of the next kept response.
  - `outstanding`: accepted requests not yet responded.
  - `drop_cnt`: responses still to discard.
  - `count`: queue occupancy.
  - Counters are `$clog2(DEPTH+1)` bits.
- Request handshake:
  - `o_req_valid` = FETCH && !i_redirect_valid && (outstanding + count < DEPTH).
  - `o_req_addr` = fetch_pc.
  - On acceptance: fetch_pc += 4, modulo 2^XLEN (wrap, no flag), and outstanding++.
  - While `o_req_valid` is 1 with `i_req_ready` 0, address and valid hold stable.
- Response handling:
  - Every response decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {data, rsp_pc, err} is pushed, and rsp_pc += 4.
  - Credit check guarantees no push into a full queue. A push that would overflow is a design error, checked by assertion.
- Error: a kept response with err=1 is enqueued normally and moves FSM to ERR. Already-accepted requests still complete and are enqueued.
- Pop: on `o_inst_valid && i_inst_ready`.
- Redirect (i_redirect_valid=1), in one cycle:
  - fetch_pc and rsp_pc load the target.
  - Queue is cleared.
  - drop_cnt loads outstanding + (req accepted this cycle ? 1 : 0) − (rsp this cycle ? 1 : 0); no request is offered this cycle, so the accept term is 0.
  - FSM goes to FETCH.
  - A simultaneous pop completes; a simultaneous response is counted as dropped.
- Requests may issue while drop_cnt>0. Stale responses arrive first in order.

## Timing
- Reset values:
  - o_req_valid=0, o_req_addr=RESET_PC.
  - o_inst_valid=0, o_inst=0, o_pc=0, o_inst_err=0.
  - All counters 0, FSM=IDLE.
- First request is in the second cycle after reset release.
- Latency: response in cycle N is pushed at edge N and visible at o_inst_* in N+1. There is no response-to-output bypass.
- Zero-wait memory (response in the cycle after acceptance) with IDU always ready: sustained 1 instruction/cycle.
- Queue empty → o_inst_valid=0. Queue full, or credits exhausted → o_req_valid=0.
- Redirect takes effect at the edge; the first request to the target is offered the following cycle.
- Reset asserted mid-operation: everything returns to reset values immediately (async). Responses to pre-reset requests are the memory's responsibility to drop.

## Structure
- `ysyx_24090003_define.v` gains `IFU_ST_IDLE`, `IFU_ST_FETCH`, `IFU_ST_ERR` (2-bit encodings) and `RESET_PC_DEFAULT`.
- One sub-module, `ysyx_24090003_sync_fifo`:
  - parameters WIDTH and DEPTH;
  - push/pop/flush ports;
  - count output;
  - async active-high reset.
- The queue entry is {err, pc, inst}.
- DPI debug hooks (set_pc/set_inst) are driven from the queue head.

## Test plan
- Reset, zero-wait memory, ready IDU → requests 0x80000000, …04, …08 on consecutive cycles; first o_inst_valid 2 cycles after first accept, o_pc sequence matches.
- IDU ready held 0, DEPTH=4 → exactly 4 accepts, then o_req_valid=0. Releasing ready for 1 cycle → one new request.
- 3 outstanding, redirect to 0x80001000 → next 3 responses dropped; first o_pc=0x80001000. Also with redirect coinciding with a response and a pop.
- i_req_ready low 5 cycles → o_req_addr stable, single accept when high.
- Response with err=1 at 0x80000008 → entry output with o_inst_err=1, no further requests; redirect resumes fetch.
- fetch_pc=0xFFFFFFFC → next address 0x00000000.

Source files
------------

// File: rtl/ysyx_24090003_ifu_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ysyx_24090003_ifu_prefetch_pkg;

  // Fetch control states (2-bit encodings).
  typedef enum logic [1:0] {
    IFU_ST_IDLE  = 2'd0,
    IFU_ST_FETCH = 2'd1,
    IFU_ST_ERR   = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ysyx_24090003_sync_fifo.sv
// Synchronous FIFO with single-edge flush and occupancy output.
// The head data reads as zero whenever the queue is empty.
module ysyx_24090003_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

  // Pointer and occupancy tracking; flush empties the queue at one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  // Upstream credit accounting must never overfill the queue.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_flush && w_full && !w_pop));

endmodule

// File: rtl/ysyx_24090003_ifu_prefetch.sv
// Instruction fetch unit with a prefetch queue: pipelined in-order fetch
// requests, credit-limited by queue space, with redirect flush and stale
// response dropping.
module ysyx_24090003_ifu_prefetch
  import ysyx_24090003_ifu_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_valid,
  input  logic [ILEN-1:0] i_rsp_data,
  input  logic            i_rsp_err,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [ILEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_inst_err
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned EW = 1 + XLEN + ILEN;

  ifu_state_e      r_state;
  ifu_state_e      w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit_used;
  logic            w_req_fire;
  logic            w_keep;
  logic            w_drop;
  logic            w_pop;
  logic            w_empty;
  logic [EW-1:0]   w_wdata;
  logic [EW-1:0]   w_rdata;

  // Requests in flight plus queued entries must never exceed the queue size.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
  assign o_req_valid   = (r_state == IFU_ST_FETCH) && !i_redirect_valid &&
                         (w_credit_used < (CW+1)'(DEPTH));
  assign o_req_addr    = r_fetch_pc;
  assign w_req_fire    = o_req_valid && i_req_ready;

  // During a redirect every response is stale, so it is dropped rather than kept.
  assign w_drop  = i_rsp_valid && (r_drop_cnt != '0);
  assign w_keep  = i_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
  assign w_pop   = o_inst_valid && i_inst_ready;
  assign w_wdata = {i_rsp_err, r_rsp_pc, i_rsp_data};

  ysyx_24090003_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_keep),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_inst_valid = !w_empty;
  assign {o_inst_err, o_pc, o_inst} = w_rdata;

  // Address, outstanding-request and drop bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(i_rsp_valid);
      if (i_redirect_valid) begin
        r_fetch_pc <= i_redirect_pc;
        r_rsp_pc   <= i_redirect_pc;
        // No request is offered during a redirect, so only the response term applies.
        r_drop_cnt <= r_outstanding - CW'(i_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_keep)     r_rsp_pc   <= r_rsp_pc + XLEN'(4);
        if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // Fetch control state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IFU_ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Fetch control next state; redirect overrides everything.
  always_comb begin
    w_state_next = r_state;
    if (i_redirect_valid) begin
      w_state_next = IFU_ST_FETCH;
    end else begin
      case (r_state)
        IFU_ST_IDLE:  w_state_next = IFU_ST_FETCH;
        IFU_ST_FETCH: if (w_keep && i_rsp_err) w_state_next = IFU_ST_ERR;
        IFU_ST_ERR:   w_state_next = IFU_ST_ERR;
        default:      w_state_next = IFU_ST_IDLE;
      endcase
    end
  end

endmodule
